fetch_unit: RTL

Front-end fetch stage of the GPU pipeline. Holds the PC, reads the instruction memory and drives the FE/DE pipeline register (PC, IR, valid) into Decode. It consumes Decode's dependency-stall and branch-stall signals. It also consumes the GPU stall, and the PC redirect from writeback. It is the transmitting end of the fetch→decode interface.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_pc_gen.sv | 41 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM states and next-PC selects.
// Imported by fetch_unit and fetch_pc_gen.
package fetch_unit_pkg;

    localparam int unsigned PC_W_DEF    = 16;
    localparam int unsigned IR_W_DEF    = 32;
    localparam int unsigned IMEM_AW_DEF = 10;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic {
        FE_RUN     = 1'b0,
        FE_BR_WAIT = 1'b1
    } fe_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with its next-PC mux.
// Selects hold, sequential +4 (wrapping) or writeback redirect.
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  pc_sel_e         sel_i,
    input  logic [PC_W-1:0] wb_pc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next-PC selection.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_HOLD:  pc_d = pc_q;
            PC_INC:   pc_d = pc_q + PC_W'(4);
            PC_REDIR: pc_d = wb_pc_i;
            default:  pc_d = pc_q;
        endcase
    end

    // PC register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= PC_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the FE/DE register from instruction memory,
// parks in BR_WAIT after a branch until writeback redirects the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEF,
    parameter int unsigned IR_W     = IR_W_DEF,
    parameter int unsigned IMEM_AW  = IMEM_AW_DEF,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET,
    input  logic               I_LOCK,
    output logic [IMEM_AW-1:0] O_IMemAddr,
    input  logic [IR_W-1:0]    I_IMemData,
    input  logic               I_DepStallSignal,
    input  logic               I_BranchStallSignal,
    input  logic               I_GPUStallSignal,
    input  logic [PC_W-1:0]    I_WriteBackPC,
    input  logic               I_WriteBackPCEn,
    output logic               O_LOCK,
    output logic [PC_W-1:0]    O_PC,
    output logic [IR_W-1:0]    O_IR,
    output logic               O_FE_Valid,
    output logic [CNT_W-1:0]   O_FetchCount,
    output logic [CNT_W-1:0]   O_BubbleCount
);

    fe_state_e        state_q, state_d;
    pc_sel_e          pc_sel;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  fe_pc_q, fe_pc_d;
    logic [IR_W-1:0]  fe_ir_q, fe_ir_d;
    logic             fe_valid_q, fe_valid_d;
    logic             lock_q;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    fetch_pc_gen #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i   (I_CLOCK),
        .rst_i   (I_RESET),
        .sel_i   (pc_sel),
        .wb_pc_i (I_WriteBackPC),
        .pc_o    (pc)
    );

    assign O_IMemAddr = pc[IMEM_AW+1:2];

    // Next state, FE/DE register, PC select and counters.
    always_comb begin
        state_d      = state_q;
        pc_sel       = PC_HOLD;
        fe_pc_d      = fe_pc_q;
        fe_ir_d      = fe_ir_q;
        fe_valid_d   = fe_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (I_LOCK) begin
            if (!fe_valid_q && bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
            unique case (state_q)
                FE_RUN: begin
                    if (I_WriteBackPCEn) begin
                        pc_sel     = PC_REDIR;
                        fe_valid_d = 1'b0;
                    end else if (I_GPUStallSignal || I_DepStallSignal) begin
                        pc_sel = PC_HOLD;
                    end else if (I_BranchStallSignal) begin
                        fe_valid_d = 1'b0;
                        fe_ir_d    = '0;
                        state_d    = FE_BR_WAIT;
                    end else begin
                        pc_sel     = PC_INC;
                        fe_ir_d    = I_IMemData;
                        fe_pc_d    = pc + PC_W'(4);
                        fe_valid_d = 1'b1;
                        if (fetch_cnt_q != '1) begin
                            fetch_cnt_d = fetch_cnt_q + 1'b1;
                        end
                    end
                end
                FE_BR_WAIT: begin
                    if (I_WriteBackPCEn) begin
                        pc_sel  = PC_REDIR;
                        state_d = FE_RUN;
                    end
                end
                default: state_d = FE_RUN;
            endcase
        end
    end

    // State, FE/DE register, lock and counter registers.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q      <= FE_RUN;
            fe_pc_q      <= '0;
            fe_ir_q      <= '0;
            fe_valid_q   <= 1'b0;
            lock_q       <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            fe_pc_q      <= fe_pc_d;
            fe_ir_q      <= fe_ir_d;
            fe_valid_q   <= fe_valid_d;
            lock_q       <= I_LOCK;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign O_LOCK        = lock_q;
    assign O_PC          = fe_pc_q;
    assign O_IR          = fe_ir_q;
    assign O_FE_Valid    = fe_valid_q;
    assign O_FetchCount  = fetch_cnt_q;
    assign O_BubbleCount = bubble_cnt_q;

endmodule
